mul_dot_accum: RTL and testbench

//   Downstream stage of the pipelined multiplier. Sums LEN consecutive products into one
//   dot-product result, then holds the result for a valid/ready consumer.

---
 rtl/mul_dot_accum.sv | 95 +++++++++
 tb/tb_mul_dot_accum.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_dot_accum.sv
// Purpose : sums LEN consecutive unsigned products into one dot product, holds it for a valid/ready consumer.
// Latency : result registered on the edge that accepts the LEN-th product; out_valid is high from that edge.
// Backpr. : in_ready = (state==ACC) | out_ready; a beat offered while in_ready=0 is dropped and sets err_drop.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   clear               synchronous flush (state/acc/cnt/out_valid/err_drop; out_sum is kept)
//   in_valid, in_prod   product stream from the multiplier, which cannot stall
//   in_ready            combinational from out_ready and state only
//   out_valid, out_ready, out_sum   completed dot product, valid/ready handshake
//   err_drop            sticky flag: a product arrived while in_ready was low
module mul_dot_accum #(
  parameter int PROD_W = 8,
  parameter int LEN    = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              err_drop
);

  // A one-element vector still needs a 1-bit counter so the port-free logic stays uniform.
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              last_beat;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_next;

  // The only combinational path through the block: out_ready -> in_ready.
  assign in_ready  = (state == S_ACC) | out_ready;
  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt == CNT_LAST);

  // cnt==0 restarts the sum, which also makes a beat accepted while draining HOLD
  // become element 0 of the next vector. Sum wraps modulo 2^ACC_W.
  assign acc_base  = (cnt == '0) ? '0 : acc;
  assign acc_next  = acc_base + ACC_W'(in_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      err_drop  <= 1'b0;
    end else if (clear) begin
      // Flush discards any beat offered this cycle without flagging it.
      state     <= S_ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        err_drop <= 1'b1;
      end

      if (accept) begin
        if (last_beat) begin
          // Completion; covers the LEN==1 drain-and-reload case in HOLD as well.
          out_sum   <= acc_next;
          acc       <= '0;
          cnt       <= '0;
          state     <= S_HOLD;
          out_valid <= 1'b1;
        end else begin
          acc       <= acc_next;
          cnt       <= cnt + CNT_W'(1);
          state     <= S_ACC;
          out_valid <= 1'b0;
        end
      end else if (state == S_HOLD && out_ready) begin
        state     <= S_ACC;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_dot_accum.sv
module tb_mul_dot_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_prod = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_sum;
  logic        err_drop;

  // Narrow-accumulator instance for the wrap and async-reset checks.
  logic        w_rst_n = 1'b0;
  logic        w_in_valid = 1'b0;
  logic [7:0]  w_in_prod = '0;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [7:0]  w_out_sum;
  logic        w_err_drop;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mul_dot_accum #(.PROD_W(8), .LEN(4), .ACC_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_prod(in_prod), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .err_drop(err_drop)
  );

  mul_dot_accum #(.PROD_W(8), .LEN(4), .ACC_W(8)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .clear(1'b0),
    .in_valid(w_in_valid), .in_prod(w_in_prod), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_ready(1'b0), .out_sum(w_out_sum),
    .err_drop(w_err_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected sum per consumed result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got %0d expected none", out_sum);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({22'd0, out_sum} !== e) begin
          n_err++;
          $display("FAIL result: got %0d expected %0d", out_sum, e);
        end
      end
    end
  end

  task automatic beat(input logic [7:0] p);
    in_valid = 1'b1;
    in_prod  = p;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // Reset state
    #12;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_sum", {22'd0, out_sum}, 0);
    check("rst_err_drop", {31'd0, err_drop}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    w_rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 basic: 4*225 = 900, out_valid for exactly one cycle
    out_ready = 1'b1;
    exp_q.push_back(900);
    repeat (4) beat(8'd225);
    @(negedge clk);
    check("t1_valid_hi", {31'd0, out_valid}, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_valid_lo", {31'd0, out_valid}, 0);
    @(posedge clk); #1;

    // T2 streaming k=1..12 -> 10, 26, 42 with in_ready never low
    begin
      int rdy_low = 0;
      for (int k = 1; k <= 12; k++) begin
        in_valid = 1'b1;
        in_prod  = 8'(k);
        if (k == 4)  exp_q.push_back(10);
        if (k == 8)  exp_q.push_back(26);
        if (k == 12) exp_q.push_back(42);
        @(negedge clk);
        if (!in_ready) rdy_low++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("t2_in_ready_low_cycles", rdy_low, 0);
    end
    idle(2);

    // T3 backpressure: 1+2+3+4 held while out_ready=0, stall beat sets err_drop
    out_ready = 1'b0;
    exp_q.push_back(10);
    beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_prod = 8'd99; end
      @(negedge clk);
      if (i == 0) check("t3_err_before", {31'd0, err_drop}, 0);
      if (i == 1 || i == 3) begin
        check("t3_hold_valid", {31'd0, out_valid}, 1);
        check("t3_hold_sum", {22'd0, out_sum}, 10);
        check("t3_in_ready", {31'd0, in_ready}, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    @(negedge clk);
    check("t3_err_drop", {31'd0, err_drop}, 1);
    check("t3_sum_after_drop", {22'd0, out_sum}, 10);
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(20);
    repeat (4) beat(8'd5);
    idle(2);
    check("t3_err_sticky", {31'd0, err_drop}, 1);

    // T4 drain and accept in the same cycle: 8 consumed once, then 7+1+1+1 = 10
    out_ready = 1'b0;
    exp_q.push_back(8);
    repeat (4) beat(8'd2);
    idle(1);
    out_ready = 1'b1;
    exp_q.push_back(10);
    beat(8'd7); beat(8'd1); beat(8'd1); beat(8'd1);
    idle(2);

    // T5 clear mid-vector with a simultaneous beat
    beat(8'd9); beat(8'd9);
    clear = 1'b1; in_valid = 1'b1; in_prod = 8'd9;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_err_cleared", {31'd0, err_drop}, 0);
    check("t5_valid_cleared", {31'd0, out_valid}, 0);
    check("t5_sum_kept", {22'd0, out_sum}, 10);
    @(posedge clk); #1;
    exp_q.push_back(4);
    repeat (4) beat(8'd1);
    idle(2);

    // Async reset mid-vector drops the partial sum
    beat(8'd3); beat(8'd3);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_sum", {22'd0, out_sum}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(4);
    repeat (4) beat(8'd1);
    idle(2);

    // T6 wrap on the 8-bit instance, then async reset mid-HOLD
    repeat (4) begin
      w_in_valid = 1'b1; w_in_prod = 8'd255;
      @(posedge clk); #1;
    end
    w_in_valid = 1'b0;
    @(negedge clk);
    check("t6_wrap_sum", {24'd0, w_out_sum}, 252);
    check("t6_wrap_valid", {31'd0, w_out_valid}, 1);
    #2 w_rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, w_out_valid}, 0);
    check("t6_rst_sum", {24'd0, w_out_sum}, 0);
    check("t6_rst_in_ready", {31'd0, w_in_ready}, 1);
    check("t6_err_drop", {31'd0, w_err_drop}, 0);
    @(posedge clk); #1;
    w_rst_n = 1'b1;

    idle(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
